// File: rtl/ram_bist_if.sv
// BIST bundle: control/status towards the system plus the RAM port.
// Latency: none (wires only).
// Backpressure: none; start is a level request sampled by the BIST when idle or done.
//
// master modport: the BIST (drives RAM port and status, reads start and ram_dout)
// slave  modport: system + RAM side (drives start and ram_dout)
interface ram_bist_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ADDR_WIDTH-1:0] err_addr;
  logic [DATA_WIDTH-1:0] err_exp;
  logic [DATA_WIDTH-1:0] err_act;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport master (
    input  start, ram_dout,
    output busy, done, pass, err_addr, err_exp, err_act,
           ram_we, ram_addr, ram_din
  );

  modport slave (
    output start, ram_dout,
    input  busy, done, pass, err_addr, err_exp, err_act,
           ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_bist.sv
// March BIST for a single-port RAM: up(w P), up(r P, w ~P), down(r ~P); first mismatch captured.
// Latency: a passing run keeps busy high for 4N+1 cycles; a failing run stops at the failing compare.
// Backpressure: start is ignored while busy; the RAM is assumed always ready (fixed read timing).
//
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   bus (master)        start in; busy/done/pass/err_addr/err_exp/err_act out;
//                       ram_we/ram_addr/ram_din out, ram_dout in
module ram_bist #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] BG         = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  ram_bist_if.master  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_W0    = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_WR    = 3'd3;
  localparam logic [2:0] S_R1    = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  localparam int XW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;

  // P(a): background XOR the address, zero-extended or truncated to the data width.
  function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
    logic [XW-1:0] t;
    t = XW'(a);
    return BG ^ t[DATA_WIDTH-1:0];
  endfunction

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  cmp_vld_q, cmp_vld_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [DATA_WIDTH-1:0] err_exp_q, err_exp_d;
  logic [DATA_WIDTH-1:0] err_act_q, err_act_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  // compare request raised by the state decode this cycle
  logic                  chk;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic [DATA_WIDTH-1:0] chk_exp;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cmp_vld_d  = 1'b0;
    cmp_addr_d = cmp_addr_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_addr_d = err_addr_q;
    err_exp_d  = err_exp_q;
    err_act_d  = err_act_q;
    chk        = 1'b0;
    chk_addr   = addr_q;
    chk_exp    = pat(addr_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d    = S_W0;
          addr_d     = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_addr_d = '0;
          err_exp_d  = '0;
          err_act_d  = '0;
        end
      end
      S_W0: begin
        if (addr_q == LAST) begin
          state_d = S_RD;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      S_RD: begin
        state_d = S_WR;
      end
      S_WR: begin
        // data for the read issued in the RD cycle is on ram_dout now
        chk      = 1'b1;
        chk_addr = addr_q;
        chk_exp  = pat(addr_q);
        if (addr_q == LAST) begin
          state_d = S_R1;
        end else begin
          state_d = S_RD;
          addr_d  = addr_q + ADDR_WIDTH'(1);
        end
      end
      S_R1: begin
        // issue a read every cycle; check the one issued the cycle before
        cmp_vld_d  = 1'b1;
        cmp_addr_d = addr_q;
        chk        = cmp_vld_q;
        chk_addr   = cmp_addr_q;
        chk_exp    = ~pat(cmp_addr_q);
        if (addr_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q - ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        chk      = 1'b1;
        chk_addr = cmp_addr_q;
        chk_exp  = ~pat(cmp_addr_q);
        state_d  = S_DONE;
        done_d   = 1'b1;
        pass_d   = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // First mismatch ends the run; the address is left where it was.
    if (chk && (bus.ram_dout != chk_exp)) begin
      state_d    = S_DONE;
      addr_d     = addr_q;
      cmp_vld_d  = 1'b0;
      done_d     = 1'b1;
      pass_d     = 1'b0;
      err_addr_d = chk_addr;
      err_exp_d  = chk_exp;
      err_act_d  = bus.ram_dout;
    end
  end

  // RAM port is registered from next-state so it lines up with the state it belongs to.
  always_comb begin
    we_d = (state_d == S_W0) || (state_d == S_WR);
    if (state_d == S_W0) begin
      din_d = pat(addr_d);
    end else if (state_d == S_WR) begin
      din_d = ~pat(addr_d);
    end else begin
      din_d = din_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_act_q  <= '0;
      we_q       <= 1'b0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_addr_q <= cmp_addr_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_addr_q <= err_addr_d;
      err_exp_q  <= err_exp_d;
      err_act_q  <= err_act_d;
      we_q       <= we_d;
      din_q      <= din_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_addr = err_addr_q;
  assign bus.err_exp  = err_exp_q;
  assign bus.err_act  = err_act_q;
  assign bus.ram_we   = we_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_din  = din_q;

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist with a behavioural RAM offering stuck-at and address-aliasing faults.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_bist_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

  ram_bist #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .BG(8'hA5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // RAM model: registered address, combinational read, optional faults
  logic [7:0] mem [8];
  logic [2:0] raddr_q = 3'd0;
  logic       alias_en = 1'b0;
  logic [2:0] faddr = 3'd0;
  logic [7:0] s1 = 8'h00;
  logic [7:0] s0 = 8'h00;
  logic [2:0] eff_addr;

  assign eff_addr = alias_en ? (bus.ram_addr & 3'b011) : bus.ram_addr;

  always @(posedge clk) begin
    if (bus.ram_we) mem[eff_addr] <= bus.ram_din;
    raddr_q <= eff_addr;
  end

  assign bus.ram_dout = (raddr_q == faddr) ? ((mem[raddr_q] | s1) & ~s0) : mem[raddr_q];

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Pulse start, optionally poke start again at busy cycle 'poke', count busy cycles.
  task automatic run_test(input int poke, output int cnt);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 200) begin
      cnt++;
      bus.start = (cnt == poke);
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (cnt >= 200) chk("busy_timeout", 32'(cnt), 32'd0);
  endtask

  typedef struct {
    logic       al;
    logic [2:0] fa;
    logic [7:0] m1;
    logic [7:0] m0;
    logic       pass;
    int         cycles;
    logic [2:0] ea;
    logic [7:0] ee;
    logic [7:0] eact;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int cnt;
    bus.start = 1'b0;

    //          alias fa    s1     s0     pass cyc  err_addr exp    act
    vecs[0] = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 33, 3'd0, 8'h00, 8'h00}; // ideal RAM
    vecs[1] = '{1'b0, 3'd5, 8'h01, 8'h00, 1'b0, 20, 3'd5, 8'hA0, 8'hA1}; // R0W1 fail
    vecs[2] = '{1'b0, 3'd2, 8'h00, 8'h80, 1'b0, 14, 3'd2, 8'hA7, 8'h27}; // bit7 sa0, R0W1
    vecs[3] = '{1'b0, 3'd2, 8'h00, 8'h01, 1'b0, 14, 3'd2, 8'hA7, 8'hA6}; // bit0 sa0, R0W1
    vecs[4] = '{1'b0, 3'd2, 8'h00, 8'h08, 1'b0, 31, 3'd2, 8'h58, 8'h50}; // bit3 sa0, R1
    vecs[5] = '{1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 10, 3'd0, 8'hA5, 8'hA1}; // addr bit2 alias
    vecs[6] = '{1'b0, 3'd7, 8'h01, 8'h00, 1'b0, 24, 3'd7, 8'hA2, 8'hA3}; // last addr, R0W1
    vecs[7] = '{1'b0, 3'd0, 8'h00, 8'h02, 1'b0, 33, 3'd0, 8'h5A, 8'h58}; // addr0, DRAIN compare
    vecs[8] = '{1'b0, 3'd7, 8'h20, 8'h00, 1'b0, 26, 3'd7, 8'h5D, 8'h7D}; // first R1 compare

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_pass", 32'(bus.pass), 32'd0);
    chk("rst_err_addr", 32'(bus.err_addr), 32'd0);
    chk("rst_err_exp", 32'(bus.err_exp), 32'd0);
    chk("rst_err_act", 32'(bus.err_act), 32'd0);
    chk("rst_we", 32'(bus.ram_we), 32'd0);
    chk("rst_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_din", 32'(bus.ram_din), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 9; i++) begin
      alias_en = vecs[i].al;
      faddr    = vecs[i].fa;
      s1       = vecs[i].m1;
      s0       = vecs[i].m0;
      run_test(-1, cnt);
      chk($sformatf("v%0d_cycles", i), 32'(cnt), 32'(vecs[i].cycles));
      chk($sformatf("v%0d_done", i), 32'(bus.done), 32'd1);
      chk($sformatf("v%0d_pass", i), 32'(bus.pass), 32'(vecs[i].pass));
      chk($sformatf("v%0d_err_addr", i), 32'(bus.err_addr), 32'(vecs[i].ea));
      chk($sformatf("v%0d_err_exp", i), 32'(bus.err_exp), 32'(vecs[i].ee));
      chk($sformatf("v%0d_err_act", i), 32'(bus.err_act), 32'(vecs[i].eact));
      chk($sformatf("v%0d_we_done", i), 32'(bus.ram_we), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_done_held", i), 32'(bus.done), 32'd1);
    end
    alias_en = 1'b0;
    s1 = 8'h00;
    s0 = 8'h00;

    // rst in cycle 10 of a run aborts it
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_we", 32'(bus.ram_we), 32'd0);
    chk("mid_rst_addr", 32'(bus.ram_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_test(-1, cnt);
    chk("after_rst_cycles", 32'(cnt), 32'd33);
    chk("after_rst_pass", 32'(bus.pass), 32'd1);

    // start pulsed while busy: no restart
    run_test(5, cnt);
    chk("poke_cycles", 32'(cnt), 32'd33);
    chk("poke_pass", 32'(bus.pass), 32'd1);

    // start held high: failing run, then automatic restart that passes
    faddr = 3'd5;
    s1    = 8'h01;
    bus.start = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (bus.busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("held1_cycles", 32'(cnt), 32'd20);
    chk("held1_done", 32'(bus.done), 32'd1);
    chk("held1_pass", 32'(bus.pass), 32'd0);
    chk("held1_err_addr", 32'(bus.err_addr), 32'd5);
    s1 = 8'h00;
    @(negedge clk);
    chk("held2_busy", 32'(bus.busy), 32'd1);
    chk("held2_done_drop", 32'(bus.done), 32'd0);
    chk("held2_err_addr", 32'(bus.err_addr), 32'd0);
    chk("held2_err_act", 32'(bus.err_act), 32'd0);
    cnt = 0;
    while (bus.busy && cnt < 200) begin
      cnt++;
      if (cnt == 5) bus.start = 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("held2_cycles", 32'(cnt), 32'd33);
    chk("held2_done", 32'(bus.done), 32'd1);
    chk("held2_pass", 32'(bus.pass), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
